// File: rtl/led_pattern_seq.sv
// led_pattern_seq: multi-channel LED sequencer driven by a fixed step timebase.
// Modes: 0 = user pattern table, 1 = chase, 2 = bounce, 3 = all off.
// Optional build macro LED_PWM_EN adds a Duty input that gates the LED drive
// with a free-running 8-bit PWM counter.
//
// Ports
//   CLK         system clock
//   RSTn        asynchronous active-low reset
//   Mode[1:0]   sequence mode select
//   Pause       freezes prescaler, step index and direction; LED_Out holds
//   Restart     synchronous pulse: back to step 0 (wins over Pause and a tick)
//   Pattern_In  table, step k at bits [k*N_LED +: N_LED]
//   Duty[7:0]   PWM duty (LED_PWM_EN builds only)
//   LED_Out     registered LED drive, 1 = on
//   Step_Idx    current step / position index
//   Step_Tick   one-cycle pulse in the cycle the advanced Step_Idx appears
//
// LED_Out follows Step_Idx and Mode with one cycle of latency. In the single
// cycle where a mode change lands, a table index beyond N_STEP-1 decodes to
// all-off. In off mode the timebase still ticks but the index stays at 0.
module led_pattern_seq #(
  parameter int unsigned CLK_HZ  = 50_000_000,
  parameter int unsigned STEP_MS = 1000,
  parameter int unsigned N_LED   = 4,
  parameter int unsigned N_STEP  = 5
) (
  input  logic                    CLK,
  input  logic                    RSTn,
  input  logic [1:0]              Mode,
  input  logic                    Pause,
  input  logic                    Restart,
  input  logic [N_LED*N_STEP-1:0] Pattern_In,
`ifdef LED_PWM_EN
  input  logic [7:0]              Duty,
`endif
  output logic [N_LED-1:0]        LED_Out,
  output logic [7:0]              Step_Idx,
  output logic                    Step_Tick
);

  localparam int unsigned STEP_CYC = CLK_HZ / 1000 * STEP_MS;
  localparam int unsigned PW       = $clog2(STEP_CYC);

  localparam logic [PW-1:0] PRESC_LAST = PW'(STEP_CYC - 1);
  localparam logic [7:0]    LAST_LED   = 8'(N_LED - 1);
  localparam logic [7:0]    LAST_STEP  = 8'(N_STEP - 1);

  localparam logic [1:0] MODE_TABLE  = 2'd0;
  localparam logic [1:0] MODE_CHASE  = 2'd1;
  localparam logic [1:0] MODE_BOUNCE = 2'd2;

  typedef enum logic {
    DIR_UP   = 1'b0,
    DIR_DOWN = 1'b1
  } dir_t;

  logic [PW-1:0]    presc_q, presc_d;
  logic [7:0]       idx_d;
  dir_t             dir_q, dir_d;
  logic             tick_d;
  logic [1:0]       mode_q;
  logic             seq_clear;
  logic [N_LED-1:0] level_q, level_d;
  logic [N_LED-1:0] tbl_row, one_hot;

  // Restart request or a freshly selected mode both zero the sequence.
  assign seq_clear = Restart || (Mode != mode_q);

  // Next-state: prescaler, step index and bounce direction.
  always_comb begin
    presc_d = presc_q;
    idx_d   = Step_Idx;
    dir_d   = dir_q;
    tick_d  = 1'b0;
    if (seq_clear) begin
      presc_d = '0;
      idx_d   = 8'd0;
      dir_d   = DIR_UP;
    end else if (!Pause) begin
      if (presc_q == PRESC_LAST) begin
        presc_d = '0;
        tick_d  = 1'b1;
        case (Mode)
          MODE_TABLE: idx_d = (Step_Idx >= LAST_STEP) ? 8'd0 : Step_Idx + 8'd1;
          MODE_CHASE: idx_d = (Step_Idx >= LAST_LED) ? 8'd0 : Step_Idx + 8'd1;
          MODE_BOUNCE: begin
            if (N_LED == 1) begin
              idx_d = 8'd0;
            end else if (dir_q == DIR_UP) begin
              // Reverse at the top so the endpoint is shown only once per sweep.
              if (Step_Idx >= LAST_LED) begin
                dir_d = DIR_DOWN;
                idx_d = Step_Idx - 8'd1;
              end else begin
                idx_d = Step_Idx + 8'd1;
              end
            end else begin
              if (Step_Idx == 8'd0) begin
                dir_d = DIR_UP;
                idx_d = 8'd1;
              end else begin
                idx_d = Step_Idx - 8'd1;
              end
            end
          end
          default: idx_d = 8'd0;
        endcase
      end else begin
        presc_d = presc_q + PW'(1);
      end
    end
  end

  // LED level decode from the current index and mode.
  always_comb begin
    tbl_row = '0;
    one_hot = '0;
    level_d = '0;
    for (int k = 0; k < int'(N_STEP); k++) begin
      if (Step_Idx == 8'(k)) tbl_row = Pattern_In[k*N_LED +: N_LED];
    end
    for (int b = 0; b < int'(N_LED); b++) begin
      one_hot[b] = (Step_Idx == 8'(b));
    end
    case (Mode)
      MODE_TABLE:              level_d = tbl_row;
      MODE_CHASE, MODE_BOUNCE: level_d = one_hot;
      default:                 level_d = '0;
    endcase
  end

  // Sequencer state registers.
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      presc_q   <= '0;
      Step_Idx  <= 8'd0;
      dir_q     <= DIR_UP;
      Step_Tick <= 1'b0;
      mode_q    <= MODE_TABLE;
      level_q   <= '0;
    end else begin
      presc_q   <= presc_d;
      Step_Idx  <= idx_d;
      dir_q     <= dir_d;
      Step_Tick <= tick_d;
      mode_q    <= Mode;
      if (!Pause) level_q <= level_d;
    end
  end

`ifdef LED_PWM_EN
  logic [7:0] pwm_cnt;

  // Free-running PWM gate; keeps running while paused.
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      pwm_cnt <= 8'd0;
      LED_Out <= '0;
    end else begin
      pwm_cnt <= pwm_cnt + 8'd1;
      LED_Out <= (Pause ? level_q : level_d) & {N_LED{pwm_cnt < Duty}};
    end
  end
`else
  assign LED_Out = level_q;
`endif

endmodule

// File: tb/tb_led_pattern_seq.sv
// Bench for led_pattern_seq at STEP_CYC=4, N_LED=4, N_STEP=3.
module tb_led_pattern_seq;

  localparam int CLK_HZ   = 1000;
  localparam int STEP_MS  = 4;
  localparam int N_LED    = 4;
  localparam int N_STEP   = 3;
  localparam int STEP_CYC = 4;

  logic        CLK = 1'b0;
  logic        RSTn = 1'b1;
  logic [1:0]  Mode = 2'd0;
  logic        Pause = 1'b0;
  logic        Restart = 1'b0;
  logic [11:0] Pattern_In = 12'hA51;
`ifdef LED_PWM_EN
  logic [7:0]  Duty = 8'd255;
  logic [7:0]  tb_pwm;
`endif
  logic [3:0]  LED_Out;
  logic [7:0]  Step_Idx;
  logic        Step_Tick;

  int n_checks = 0;
  int n_fail   = 0;

  led_pattern_seq #(
    .CLK_HZ (CLK_HZ),
    .STEP_MS(STEP_MS),
    .N_LED  (N_LED),
    .N_STEP (N_STEP)
  ) dut (
    .CLK       (CLK),
    .RSTn      (RSTn),
    .Mode      (Mode),
    .Pause     (Pause),
    .Restart   (Restart),
    .Pattern_In(Pattern_In),
`ifdef LED_PWM_EN
    .Duty      (Duty),
`endif
    .LED_Out   (LED_Out),
    .Step_Idx  (Step_Idx),
    .Step_Tick (Step_Tick)
  );

  always #5 CLK = ~CLK;

`ifdef LED_PWM_EN
  // Count of clock edges since reset release, i.e. the spec's PWM counter value.
  always @(posedge CLK or negedge RSTn) begin
    if (!RSTn) tb_pwm <= 8'd0;
    else       tb_pwm <= tb_pwm + 8'd1;
  end
`endif

  // Expected LED drive after PWM gating (identity without PWM).
  function automatic logic [3:0] gate(input logic [3:0] lvl);
`ifdef LED_PWM_EN
    logic [7:0] prev;
    prev = tb_pwm - 8'd1;
    return (prev < Duty) ? lvl : 4'h0;
`else
    return lvl;
`endif
  endfunction

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic clk_edge();
    @(posedge CLK);
    #1;
  endtask

  task automatic wait_tick(input int budget, output bit ok);
    ok = 1'b0;
    for (int c = 0; c < budget; c++) begin
      clk_edge();
      if (Step_Tick) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  // ---------------- reference model ----------------
  int         m_cnt, m_n;
  logic [1:0] m_mq;
  logic [3:0] m_level;
  logic       m_tick;

  // Position after n completed steps, from the sequence definitions.
  function automatic int idx_of(input logic [1:0] m, input int n);
    int per, p;
    case (m)
      2'd0: return n % N_STEP;
      2'd1: return n % N_LED;
      2'd2: begin
        if (N_LED == 1) return 0;
        per = 2 * (N_LED - 1);
        p   = n % per;
        return (p < N_LED) ? p : per - p;
      end
      default: return 0;
    endcase
  endfunction

  function automatic logic [3:0] decode(input logic [1:0] m, input int idx, input logic [11:0] pat);
    logic [11:0] sh;
    case (m)
      2'd0: begin
        if (idx >= N_STEP) return 4'h0;
        sh = pat >> (4 * idx);
        return sh[3:0];
      end
      2'd1, 2'd2: return 4'(1 << idx);
      default: return 4'h0;
    endcase
  endfunction

  task automatic model_reset();
    m_cnt = 0; m_n = 0; m_mq = 2'd0; m_level = 4'h0; m_tick = 1'b0;
  endtask

  task automatic model_step();
    int pre;
    pre = idx_of(m_mq, m_n);
    if (!Pause) m_level = decode(Mode, pre, Pattern_In);
    if (Restart || Mode != m_mq) begin
      m_cnt = 0; m_n = 0; m_tick = 1'b0;
    end else if (!Pause) begin
      m_cnt++;
      m_tick = 1'b0;
      if (m_cnt == STEP_CYC) begin
        m_cnt = 0; m_n++; m_tick = 1'b1;
      end
    end else begin
      m_tick = 1'b0;
    end
    m_mq = Mode;
  endtask

  // ---------------- directed vectors ----------------
  typedef struct {
    logic [1:0] mode;
    logic       pause;
    logic       restart;
    logic       chk_led;
    logic [3:0] led;
    logic [7:0] idx;
    logic       tick;
    int         reps;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic [1:0] m, input logic p, input logic r, input logic cl,
                              input logic [3:0] l, input logic [7:0] i, input logic t, input int n);
    vec_t v;
    v.mode = m; v.pause = p; v.restart = r; v.chk_led = cl;
    v.led = l; v.idx = i; v.tick = t; v.reps = n;
    return v;
  endfunction

  int bexp[8] = '{0, 1, 2, 3, 2, 1, 0, 1};

  initial begin
    bit ok;
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit ok;
    // Table pattern A51: steps show 1,5,A then wrap; ticks every 4 cycles.
    vecs.push_back(mk(2'd0, 0, 0, 1, 4'h1, 8'd0, 0, 3));
    vecs.push_back(mk(2'd0, 0, 0, 1, 4'h1, 8'd1, 1, 1));
    vecs.push_back(mk(2'd0, 0, 0, 1, 4'h5, 8'd1, 0, 3));
    vecs.push_back(mk(2'd0, 0, 0, 1, 4'h5, 8'd2, 1, 1));
    vecs.push_back(mk(2'd0, 0, 0, 1, 4'hA, 8'd2, 0, 3));
    vecs.push_back(mk(2'd0, 0, 0, 1, 4'hA, 8'd0, 1, 1));
    vecs.push_back(mk(2'd0, 0, 0, 1, 4'h1, 8'd0, 0, 3));
    vecs.push_back(mk(2'd0, 0, 0, 1, 4'h1, 8'd1, 1, 1));
    // Switch to chase: sequence restarts, then 1,2,4,8,1.
    vecs.push_back(mk(2'd1, 0, 0, 0, 4'h0, 8'd0, 0, 1));
    vecs.push_back(mk(2'd1, 0, 0, 1, 4'h1, 8'd0, 0, 3));
    vecs.push_back(mk(2'd1, 0, 0, 1, 4'h1, 8'd1, 1, 1));
    vecs.push_back(mk(2'd1, 0, 0, 1, 4'h2, 8'd1, 0, 3));
    vecs.push_back(mk(2'd1, 0, 0, 1, 4'h2, 8'd2, 1, 1));
    vecs.push_back(mk(2'd1, 0, 0, 1, 4'h4, 8'd2, 0, 3));
    vecs.push_back(mk(2'd1, 0, 0, 1, 4'h4, 8'd3, 1, 1));
    vecs.push_back(mk(2'd1, 0, 0, 1, 4'h8, 8'd3, 0, 3));
    vecs.push_back(mk(2'd1, 0, 0, 1, 4'h8, 8'd0, 1, 1));
    vecs.push_back(mk(2'd1, 0, 0, 1, 4'h1, 8'd0, 0, 1));

    // Reset state
    #2 RSTn = 1'b0;
    repeat (2) clk_edge();
    check("reset LED_Out", int'(LED_Out), 0);
    check("reset Step_Idx", int'(Step_Idx), 0);
    check("reset Step_Tick", int'(Step_Tick), 0);
    @(negedge CLK);
    RSTn = 1'b1;

    foreach (vecs[i]) begin
      for (int r = 0; r < vecs[i].reps; r++) begin
        Mode = vecs[i].mode; Pause = vecs[i].pause; Restart = vecs[i].restart;
        clk_edge();
        check($sformatf("vec%0d.%0d Step_Idx", i, r), int'(Step_Idx), int'(vecs[i].idx));
        check($sformatf("vec%0d.%0d Step_Tick", i, r), int'(Step_Tick), int'(vecs[i].tick));
        if (vecs[i].chk_led)
          check($sformatf("vec%0d.%0d LED_Out", i, r), int'(LED_Out), int'(gate(vecs[i].led)));
      end
    end

    // Pause mid-step: frozen for 10 cycles, then resumes with the remaining count.
    Mode = 2'd1; Restart = 1'b1;
    clk_edge();
    Restart = 1'b0;
    check("restart Step_Idx", int'(Step_Idx), 0);
    repeat (2) clk_edge();
    Pause = 1'b1;
    for (int c = 0; c < 10; c++) begin
      clk_edge();
      check($sformatf("pause%0d Step_Tick", c), int'(Step_Tick), 0);
      check($sformatf("pause%0d Step_Idx", c), int'(Step_Idx), 0);
      check($sformatf("pause%0d LED_Out", c), int'(LED_Out), int'(gate(4'h1)));
    end
    Pause = 1'b0;
    clk_edge();
    check("resume first Step_Tick", int'(Step_Tick), 0);
    clk_edge();
    check("resume second Step_Tick", int'(Step_Tick), 1);
    check("resume Step_Idx", int'(Step_Idx), 1);

    // Restart together with Pause on the cycle a tick is due.
    for (int c = 0; c < 3; c++) begin
      clk_edge();
      check($sformatf("pre-restart%0d Step_Tick", c), int'(Step_Tick), 0);
    end
    Restart = 1'b1; Pause = 1'b1;
    clk_edge();
    Restart = 1'b0; Pause = 1'b0;
    check("restart+pause Step_Idx", int'(Step_Idx), 0);
    check("restart+pause Step_Tick", int'(Step_Tick), 0);
    for (int c = 1; c <= 4; c++) begin
      clk_edge();
      check($sformatf("post-restart%0d Step_Tick", c), int'(Step_Tick), (c == 4) ? 1 : 0);
    end
    check("post-restart Step_Idx", int'(Step_Idx), 1);

    // Bounce sweep 0,1,2,3,2,1,0,1.
    Mode = 2'd2;
    clk_edge();
    check("bounce start Step_Idx", int'(Step_Idx), bexp[0]);
    check("bounce start Step_Tick", int'(Step_Tick), 0);
    for (int k = 1; k < 8; k++) begin
      wait_tick(8, ok);
      check($sformatf("bounce tick%0d seen", k), int'(ok), 1);
      check($sformatf("bounce step%0d Step_Idx", k), int'(Step_Idx), bexp[k]);
    end

    // Asynchronous reset mid-sequence.
    clk_edge();
    check("bounce LED before reset", int'(LED_Out), int'(gate(4'h2)));
    #2 RSTn = 1'b0;
    #1;
    check("async reset LED_Out", int'(LED_Out), 0);
    check("async reset Step_Idx", int'(Step_Idx), 0);
    check("async reset Step_Tick", int'(Step_Tick), 0);

    // Randomised run against the reference model.
    Mode = 2'd0; Pause = 1'b0; Restart = 1'b0;
    repeat (2) clk_edge();
    @(negedge CLK);
    RSTn = 1'b1;
    model_reset();
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 29) == 0) Mode = 2'($urandom_range(0, 3));
      Pause   = ($urandom_range(0, 9) == 0);
      Restart = ($urandom_range(0, 39) == 0);
      if ($urandom_range(0, 199) == 0) Pattern_In = 12'($urandom);
      clk_edge();
      model_step();
      check($sformatf("rand%0d Step_Idx", c), int'(Step_Idx), idx_of(m_mq, m_n));
      check($sformatf("rand%0d Step_Tick", c), int'(Step_Tick), int'(m_tick));
      check($sformatf("rand%0d LED_Out", c), int'(LED_Out), int'(gate(m_level)));
    end

`ifdef LED_PWM_EN
    // Duty 64 on chase step 0, frozen by Pause while PWM keeps running.
    begin
      int hi;
      Mode = 2'd1; Restart = 1'b1; Pause = 1'b0; Duty = 8'd64;
      clk_edge();
      Restart = 1'b0;
      clk_edge();
      Pause = 1'b1;
      hi = 0;
      repeat (256) begin
        clk_edge();
        if (LED_Out[0]) hi++;
      end
      check("pwm duty64 on-cycles", hi, 64);
      Duty = 8'd0;
      clk_edge();
      hi = 0;
      repeat (32) begin
        clk_edge();
        if (LED_Out != 4'h0) hi++;
      end
      check("pwm duty0 on-cycles", hi, 0);
      Pause = 1'b0;
    end
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
